// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: register address, writeback request and sizing constants.
// Pure declarations; no latency or flow control of its own.
package rv32_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_NREG   = 32;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic                 valid;
    reg_addr_t            rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // x0 is hardwired zero, so a request targeting it never occupies the write port.
  function automatic logic writes_rf(input logic valid, input reg_addr_t rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback port bundle: ALU result, handshaked LSU/mul-div response, issue/hazard lines, RF write port.
// Only lsu_valid_i/lsu_ready_o carry backpressure; every other signal is sampled or driven per cycle.
interface writeback_stage_if
  import rv32_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = $clog2(WB_NREG)
);

  logic              alu_valid_i;
  logic [REG_AW-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;

  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;

  logic              issue_long_i;
  logic [REG_AW-1:0] issue_rd_i;
  logic [REG_AW-1:0] rs1_addr_i;
  logic [REG_AW-1:0] rs2_addr_i;
  logic              hazard_o;

  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_long_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    output lsu_ready_o, hazard_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_long_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  lsu_ready_o, hazard_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy bits for in-flight long-latency destinations; set/clear on the clock edge, two combinational reads.
// Set wins over a same-cycle clear of the same register; bit 0 is never busy.
module wb_scoreboard
  import rv32_pkg::*;
#(
  parameter  int NREG = WB_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] ra0_i,
  input  logic [AW-1:0] ra1_i,
  output logic          busy0_o,
  output logic          busy1_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy0_o = busy_q[ra0_i];
  assign busy1_o = busy_q[ra1_i];

  // Decode must stall on WAW, unless the old result retires on this very edge.
  a_no_waw_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (set_en_i && !(clr_en_i && (clr_addr_i == set_addr_i))) |-> !busy_q[set_addr_i]);

  a_resp_was_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    clr_en_i |-> busy_q[clr_addr_i]);

endmodule

// File: rtl/writeback_stage.sv
// Merges ALU results and LSU/mul-div responses onto the single RF write port; 1-cycle registered write.
// ALU is never stalled; an LSU response losing to the ALU parks in a 1-entry hold and drops lsu_ready_o.
module writeback_stage
  import rv32_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int NREG   = WB_NREG,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  writeback_stage_if.slave   wb
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t hold_q, hold_d;
  req_t win;
  logic win_long;

  logic alu_wr, lsu_fire, lsu_wr, set_en;

  logic              rf_we_q,    rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic busy_rs1, busy_rs2;

  assign wb.lsu_ready_o = !hold_q.valid;
  assign lsu_fire       = wb.lsu_valid_i && !hold_q.valid;
  assign alu_wr         = writes_rf(wb.alu_valid_i, wb.alu_rd_i);
  assign lsu_wr         = writes_rf(lsu_fire, wb.lsu_rd_i);
  assign set_en         = writes_rf(wb.issue_long_i, wb.issue_rd_i);

  // Write-port arbitration: ALU, then the parked response, then a fresh LSU response.
  always_comb begin
    hold_d   = hold_q;
    win      = '0;
    win_long = 1'b0;
    if (alu_wr) begin
      win.valid = 1'b1;
      win.rd    = wb.alu_rd_i;
      win.data  = wb.alu_data_i;
      if (lsu_wr) begin
        hold_d.valid = 1'b1;
        hold_d.rd    = wb.lsu_rd_i;
        hold_d.data  = wb.lsu_data_i;
      end
    end else if (hold_q.valid) begin
      win          = hold_q;
      win_long     = 1'b1;
      hold_d.valid = 1'b0;
    end else if (lsu_wr) begin
      win.valid = 1'b1;
      win.rd    = wb.lsu_rd_i;
      win.data  = wb.lsu_data_i;
      win_long  = 1'b1;
    end
  end

  always_comb begin
    rf_we_d    = win.valid;
    rf_waddr_d = win.valid ? win.rd   : rf_waddr_q;
    rf_wdata_d = win.valid ? win.data : rf_wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      hold_q     <= hold_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign wb.rf_we_o    = rf_we_q;
  assign wb.rf_waddr_o = rf_waddr_q;
  assign wb.rf_wdata_o = rf_wdata_q;

  // Busy clears on the edge that loads the write, so hazard drops in the rf_we_o cycle (write-first RF).
  wb_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_en_i   (set_en),
    .set_addr_i (wb.issue_rd_i),
    .clr_en_i   (win_long),
    .clr_addr_i (win.rd),
    .ra0_i      (wb.rs1_addr_i),
    .ra1_i      (wb.rs2_addr_i),
    .busy0_o    (busy_rs1),
    .busy1_o    (busy_rs2)
  );

  assign wb.hazard_o = busy_rs1 | busy_rs2;

  a_hold_blocks_fire: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hold_q.valid |-> !lsu_fire);

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table for ALU writes, directed multi-cycle sequences,
// and a queue scoreboard checking every RF write in order.
module tb_writeback_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  writeback_stage_if wb ();

  writeback_stage dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .wb     (wb)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_wr_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  exp_wr_t sb_q[$];
  int      n_assert = 0;
  int      n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_wr_t e;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Every clock edge of the run goes through here, so each RF write is seen exactly once.
  task automatic sb_sample();
    exp_wr_t e;
    if (wb.rf_we_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL sb_unexpected_write: waddr %0d wdata %0h with empty queue", wb.rf_waddr_o, wb.rf_wdata_o);
      end else begin
        e = sb_q.pop_front();
        chk("sb_waddr", 32'(wb.rf_waddr_o), 32'(e.rd));
        chk("sb_wdata", wb.rf_wdata_o, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  task automatic idle();
    wb.alu_valid_i  = 1'b0;
    wb.alu_rd_i     = '0;
    wb.alu_data_i   = '0;
    wb.lsu_valid_i  = 1'b0;
    wb.lsu_rd_i     = '0;
    wb.lsu_data_i   = '0;
    wb.issue_long_i = 1'b0;
    wb.issue_rd_i   = '0;
    wb.rs1_addr_i   = '0;
    wb.rs2_addr_i   = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    wb.issue_long_i = 1'b1;
    wb.issue_rd_i   = rd;
    step();
    wb.issue_long_i = 1'b0;
    wb.issue_rd_i   = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    vecs[3] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b0, 5'd9,  32'hAAAA5555, 1'b0, 5'd0,  32'h0};

    // Reset state
    rst_ni = 1'b0;
    idle();
    #2;
    chk("rst_we",    32'(wb.rf_we_o), 32'd0);
    chk("rst_waddr", 32'(wb.rf_waddr_o), 32'd0);
    chk("rst_wdata", wb.rf_wdata_o, 32'd0);
    chk("rst_ready", 32'(wb.lsu_ready_o), 32'd1);
    for (int i = 0; i < 32; i++) begin
      wb.rs1_addr_i = 5'(i);
      wb.rs2_addr_i = 5'(31 - i);
      #1;
      chk("rst_hazard", 32'(wb.hazard_o), 32'd0);
    end
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    step();
    chk("idle_we",    32'(wb.rf_we_o), 32'd0);
    chk("idle_ready", 32'(wb.lsu_ready_o), 32'd1);

    // ALU write vectors, each followed by an idle cycle to confirm a single-cycle pulse
    for (int i = 0; i < 5; i++) begin
      wb.alu_valid_i = vecs[i].alu_v;
      wb.alu_rd_i    = vecs[i].rd;
      wb.alu_data_i  = vecs[i].data;
      if (vecs[i].exp_we) push(vecs[i].exp_waddr, vecs[i].exp_wdata);
      step();
      chk("tbl_we", 32'(wb.rf_we_o), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk("tbl_waddr", 32'(wb.rf_waddr_o), 32'(vecs[i].exp_waddr));
        chk("tbl_wdata", wb.rf_wdata_o, vecs[i].exp_wdata);
      end
      idle();
      step();
      chk("tbl_pulse", 32'(wb.rf_we_o), 32'd0);
    end

    // Long op to x7: hazard while busy, cleared in the write cycle
    issue(5'd7);
    wb.rs1_addr_i = 5'd7;
    #1;
    chk("t3_hazard_busy", 32'(wb.hazard_o), 32'd1);
    chk("t3_ready", 32'(wb.lsu_ready_o), 32'd1);
    wb.lsu_valid_i = 1'b1;
    wb.lsu_rd_i    = 5'd7;
    wb.lsu_data_i  = 32'h1234;
    push(5'd7, 32'h1234);
    step();
    wb.lsu_valid_i = 1'b0;
    chk("t3_we",     32'(wb.rf_we_o), 32'd1);
    chk("t3_waddr",  32'(wb.rf_waddr_o), 32'd7);
    chk("t3_wdata",  wb.rf_wdata_o, 32'h1234);
    chk("t3_hazard_clr", 32'(wb.hazard_o), 32'd0);
    idle();
    step();

    // ALU and LSU collide: LSU parks in hold for exactly one cycle
    issue(5'd9);
    wb.rs2_addr_i  = 5'd9;
    wb.alu_valid_i = 1'b1;
    wb.alu_rd_i    = 5'd3;
    wb.alu_data_i  = 32'h33;
    wb.lsu_valid_i = 1'b1;
    wb.lsu_rd_i    = 5'd9;
    wb.lsu_data_i  = 32'h99;
    push(5'd3, 32'h33);
    push(5'd9, 32'h99);
    step();
    wb.alu_valid_i = 1'b0;
    wb.lsu_valid_i = 1'b0;
    chk("t4_waddr_alu", 32'(wb.rf_waddr_o), 32'd3);
    chk("t4_ready_low", 32'(wb.lsu_ready_o), 32'd0);
    chk("t4_hazard",    32'(wb.hazard_o), 32'd1);
    step();
    chk("t4_we_hold",    32'(wb.rf_we_o), 32'd1);
    chk("t4_waddr_hold", 32'(wb.rf_waddr_o), 32'd9);
    chk("t4_ready_back", 32'(wb.lsu_ready_o), 32'd1);
    chk("t4_hazard_clr", 32'(wb.hazard_o), 32'd0);
    step();
    chk("t4_idle_we", 32'(wb.rf_we_o), 32'd0);
    idle();

    // ALU to x0 does not take the port; long issue to x0 never marks busy
    issue(5'd4);
    wb.alu_valid_i = 1'b1;
    wb.alu_rd_i    = 5'd0;
    wb.alu_data_i  = 32'hFF;
    wb.lsu_valid_i = 1'b1;
    wb.lsu_rd_i    = 5'd4;
    wb.lsu_data_i  = 32'h44;
    push(5'd4, 32'h44);
    step();
    idle();
    chk("t5_waddr", 32'(wb.rf_waddr_o), 32'd4);
    chk("t5_wdata", wb.rf_wdata_o, 32'h44);
    chk("t5_no_hold", 32'(wb.lsu_ready_o), 32'd1);
    issue(5'd0);
    chk("t5_x0_hazard", 32'(wb.hazard_o), 32'd0);
    chk("t5_x0_we", 32'(wb.rf_we_o), 32'd0);

    // Same-edge clear and re-set of x15: set wins
    issue(5'd15);
    wb.rs2_addr_i   = 5'd15;
    wb.lsu_valid_i  = 1'b1;
    wb.lsu_rd_i     = 5'd15;
    wb.lsu_data_i   = 32'h15;
    wb.issue_long_i = 1'b1;
    wb.issue_rd_i   = 5'd15;
    push(5'd15, 32'h15);
    step();
    wb.issue_long_i = 1'b0;
    wb.lsu_data_i   = 32'h1515;
    chk("setwin_waddr",  32'(wb.rf_waddr_o), 32'd15);
    chk("setwin_hazard", 32'(wb.hazard_o), 32'd1);
    push(5'd15, 32'h1515);
    step();
    wb.lsu_valid_i = 1'b0;
    chk("setwin_clr", 32'(wb.hazard_o), 32'd0);
    idle();

    // Hold full while ALU keeps winning for three cycles
    issue(5'd10);
    wb.rs1_addr_i  = 5'd10;
    wb.alu_valid_i = 1'b1;
    wb.alu_rd_i    = 5'd1;
    wb.alu_data_i  = 32'h1;
    wb.lsu_valid_i = 1'b1;
    wb.lsu_rd_i    = 5'd10;
    wb.lsu_data_i  = 32'hA0A0;
    push(5'd1, 32'h1);
    step();
    wb.lsu_valid_i = 1'b0;
    chk("t6_ready0", 32'(wb.lsu_ready_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      wb.alu_rd_i   = 5'(11 + k);
      wb.alu_data_i = 32'h100 + 32'(k);
      push(5'(11 + k), 32'h100 + 32'(k));
      step();
      chk("t6_alu_waddr", 32'(wb.rf_waddr_o), 32'(11 + k));
      chk("t6_ready_low", 32'(wb.lsu_ready_o), 32'd0);
      chk("t6_hazard",    32'(wb.hazard_o), 32'd1);
    end
    wb.alu_valid_i = 1'b0;
    push(5'd10, 32'hA0A0);
    step();
    chk("t6_hold_waddr", 32'(wb.rf_waddr_o), 32'd10);
    chk("t6_hold_clr",   32'(wb.hazard_o), 32'd0);
    chk("t6_ready_back", 32'(wb.lsu_ready_o), 32'd1);
    idle();
    step();

    // Asynchronous reset with hold full and busy set
    issue(5'd20);
    wb.rs1_addr_i  = 5'd20;
    wb.alu_valid_i = 1'b1;
    wb.alu_rd_i    = 5'd2;
    wb.alu_data_i  = 32'h22;
    wb.lsu_valid_i = 1'b1;
    wb.lsu_rd_i    = 5'd20;
    wb.lsu_data_i  = 32'h2020;
    push(5'd2, 32'h22);
    step();
    wb.lsu_valid_i = 1'b0;
    wb.alu_rd_i    = 5'd3;
    wb.alu_data_i  = 32'h3333;
    chk("rst_pre_ready",  32'(wb.lsu_ready_o), 32'd0);
    chk("rst_pre_hazard", 32'(wb.hazard_o), 32'd1);
    #4;
    rst_ni = 1'b0;
    #1;
    chk("arst_we",     32'(wb.rf_we_o), 32'd0);
    chk("arst_waddr",  32'(wb.rf_waddr_o), 32'd0);
    chk("arst_wdata",  wb.rf_wdata_o, 32'd0);
    chk("arst_ready",  32'(wb.lsu_ready_o), 32'd1);
    chk("arst_hazard", 32'(wb.hazard_o), 32'd0);
    idle();
    wb.rs1_addr_i = 5'd20;
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    step();
    chk("post_rst_we",     32'(wb.rf_we_o), 32'd0);
    chk("post_rst_ready",  32'(wb.lsu_ready_o), 32'd1);
    chk("post_rst_hazard", 32'(wb.hazard_o), 32'd0);
    step();

    chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
